crc32_mb: RTL and testbench
===========================

# crc32_mb

Multi-byte-per-cycle CRC-32 engine for the PNG chunk writer: accepts DATA_BYTES bytes per beat, accumulates the PNG/zlib CRC-32 over chunk type and data, and presents the final 32-bit CRC, already reflected and inverted, with a completion handshake. It sits beside the chunk packer and replaces the single-byte CRC core. A small run/idle FSM supports back-to-back chunks and abort/restart.

## Interface
- DATA_BYTES, 4: bytes per input beat; legal values 1, 2, 4, 8.
- NB_WD, $clog2(DATA_BYTES) (minimum 1): width of `nbyte_i`.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  one-cycle pulse that seeds a new CRC computation.
- val_i  in  1  input beat valid.
- dat_i  in  8*DATA_BYTES  beat data; `dat_i[7:0]` is the first byte in stream order.
- lst_i  in  1  qualifies the last beat of the chunk; sampled only with `val_i`.
- nbyte_i  in  NB_WD  number of valid bytes on the last beat; 0 means all DATA_BYTES. Present only with CRC32_PARTIAL_EN.
- busy_o  out  1  high while in RUN.
- val_o  out  1  one-cycle pulse when `dat_o` is updated with a final CRC.
- done_o  out  1  level; high from completion until the next `start_i`.
- dat_o  out  32  final CRC; PNG byte order is `dat_o[31:24]` first.

## Operation
- CRC-32 uses reflected polynomial 0xEDB88320, init 0xFFFFFFFF, and final XOR 0xFFFFFFFF. Each byte is processed LSB-first.
- The internal register `crc_r` holds the raw reflected value.
- A beat is processed byte 0 to byte DATA_BYTES-1. It is one chained combinational update and the result is registered in the same cycle.
- FSM states:
  - IDLE: `start_i` goes to RUN. `val_i` without `start_i` is ignored.
  - RUN: `val_i` updates `crc_r`. `val_i & lst_i` loads `dat_o` = `~crc_r_next`, pulses `val_o`, sets `done_o`, and goes to IDLE.
  - `start_i` in RUN aborts the current computation: `crc_r` is reseeded, it stays in RUN, and no `val_o` is issued.
- `start_i` and `val_i` in the same cycle: the beat is processed with seed 0xFFFFFFFF, so `start_i` takes precedence as the seed.
- `start_i`, `val_i` and `lst_i` in the same cycle: this is a single-beat chunk and completes in that cycle.
- `start_i` clears `done_o`. `dat_o` holds its value until the next completion.
- `lst_i` without `val_i` is ignored.
- There is no backpressure: one beat per cycle is accepted indefinitely.

## Timing
- Reset values:
  - FSM: IDLE.
  - `crc_r`: 0xFFFFFFFF.
  - `dat_o`: 0x00000000.
  - `val_o`, `done_o`, `busy_o`: 0.
- Latency: the last beat at edge N gives `val_o`=1 and valid `dat_o` in cycle N+1 (registered).
- Back-to-back chunks are supported: `start_i` may coincide with the `val_o` cycle of the previous chunk.
- `busy_o` rises the cycle after `start_i` and falls the cycle after the last beat.
- Reset mid-chunk discards all state. No `val_o` is issued.

## Configuration
- `CRC32_PARTIAL_EN` defined:
  - Adds the `nbyte_i` port.
  - On the last beat only bytes 0..`nbyte_i`-1 (0 means all) update the CRC; the upper bytes are don't-care.
  - Non-last beats are always full.
- `CRC32_PARTIAL_EN` undefined:
  - No `nbyte_i` port.
  - Every beat is full, so chunk length must be a multiple of DATA_BYTES.
  - The upstream packer must use DATA_BYTES=1 or pad the chunk.

## Structure
- Package `crc32_pkg`:
  - `CRC32_POLY_R` = 32'hEDB88320, `CRC32_INIT` = 32'hFFFFFFFF, `CRC32_XOROUT` = 32'hFFFFFFFF.
  - FSM state typedef (IDLE, RUN).
  - Function `crc32_byte(crc, byte)`.
- Sub-module `crc32_byte_step`: a combinational single-byte reflected update, instantiated DATA_BYTES times in a chain. Byte masking for partial beats selects the tap after byte `nbyte_i`-1.

## Test plan
- DATA_BYTES=1, `start_i` then "123456789" with `lst_i` on '9' -> `val_o` pulse one cycle later, `dat_o`=0xCBF43926, `done_o`=1.
- DATA_BYTES=4, full beats "IEND" with `start_i`+`val_i`+`lst_i` in the same cycle -> `dat_o`=0xAE426082 the next cycle.
- DATA_BYTES=4 with `CRC32_PARTIAL_EN`, beats "1234", "5678", "9xxx" with `nbyte_i`=1 -> `dat_o`=0xCBF43926. Also the single beat "a" with `nbyte_i`=1 -> 0xE8B7BE43.
- Abort: `start_i`, two beats of garbage, `start_i`, then "IEND" -> exactly one `val_o`, with `dat_o`=0xAE426082.
- Back-to-back: "IEND" completes, and `start_i` for "123456789" arrives in the `val_o` cycle -> both CRCs are correct. `done_o` drops the cycle after the second `start_i`.
- `rstn` asserted mid-chunk -> all outputs return to their reset values immediately. `val_i` beats in IDLE afterwards leave `crc_r` unchanged and produce no `val_o`.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and the single-byte reflected update
// used by the PNG/zlib CRC-32 engine.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } crc32_state_e;

    // Byte enters LSB-first: fold it into the low bits, then shift out eight bits.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) begin
            if (c[0]) c = (c >> 1) ^ CRC32_POLY_R;
            else      c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte reflected CRC-32 update; one link of the beat chain.
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, byte_i);

endmodule

// File: rtl/crc32_mb.sv
// Multi-byte-per-cycle CRC-32 engine with run/idle FSM and completion handshake.
// Build option CRC32_PARTIAL_EN adds nbyte_i for a partially filled last beat.
module crc32_mb
    import crc32_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int NB_WD      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_i,
    input  logic                    val_i,
    input  logic [8*DATA_BYTES-1:0] dat_i,
    input  logic                    lst_i,
`ifdef CRC32_PARTIAL_EN
    input  logic [NB_WD-1:0]        nbyte_i,
`endif
    output logic                    busy_o,
    output logic                    val_o,
    output logic                    done_o,
    output logic [31:0]             dat_o
);

    // Handshake: no backpressure. A beat is taken on any rising edge where
    // val_i is high and the FSM is in RUN or start_i is high in that cycle;
    // lst_i only counts together with val_i. val_o is a one-cycle pulse in
    // the cycle after the last beat, done_o stays high until the next start_i.

    crc32_state_e state_q, state_d;
    logic [31:0]  crc_q, crc_d;
    logic [31:0]  dat_q, dat_d;
    logic         val_q, val_d;
    logic         done_q, done_d;

    logic [31:0]  seed;
    logic [31:0]  crc_next;
    logic [31:0]  tap [DATA_BYTES];
    logic         accept;

    // start_i reseeds even when a beat arrives in the same cycle.
    assign seed = start_i ? CRC32_INIT : crc_q;

    // tap[i] is the CRC after bytes 0..i of the current beat.
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_chain
        logic [31:0] c_in;
        logic [31:0] c_out;
        if (i == 0) begin : g_first
            assign c_in = seed;
        end else begin : g_next
            assign c_in = g_chain[i-1].c_out;
        end
        crc32_byte_step u_step (
            .crc_i  (c_in),
            .byte_i (dat_i[8*i +: 8]),
            .crc_o  (c_out)
        );
        assign tap[i] = c_out;
    end

    always_comb begin
        crc_next = tap[DATA_BYTES-1];
`ifdef CRC32_PARTIAL_EN
        if (lst_i) begin
            for (int i = 1; i < DATA_BYTES; i++) begin
                if (nbyte_i == NB_WD'(i)) crc_next = tap[i-1];
            end
        end
`endif
    end

    assign accept = val_i && (start_i || (state_q == RUN));

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        dat_d   = dat_q;
        val_d   = 1'b0;
        done_d  = done_q;
        if (start_i) begin
            state_d = RUN;
            crc_d   = CRC32_INIT;
            done_d  = 1'b0;
        end
        if (accept) begin
            crc_d = crc_next;
            if (lst_i) begin
                dat_d   = crc_next ^ CRC32_XOROUT;
                val_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            dat_q   <= 32'h00000000;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign val_o  = val_q;
    assign done_o = done_q;
    assign dat_o  = dat_q;

endmodule

// File: tb/tb_crc32_mb.sv
// Directed bench for crc32_mb: a 4-byte and a 1-byte instance share clock and reset.
// Set CRC32_PARTIAL_EN to also cover partial last beats.
module tb_crc32_mb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        s4, v4, l4, b4, vo4, dn4;
    logic [31:0] d4, o4;
    logic [1:0]  nb4;
    logic        s1, v1, l1, b1, vo1, dn1;
    logic [7:0]  d1;
    logic [31:0] o1;
    logic [0:0]  nb1;

    crc32_mb #(.DATA_BYTES(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .start_i(s4), .val_i(v4), .dat_i(d4), .lst_i(l4),
`ifdef CRC32_PARTIAL_EN
        .nbyte_i(nb4),
`endif
        .busy_o(b4), .val_o(vo4), .done_o(dn4), .dat_o(o4)
    );

    crc32_mb #(.DATA_BYTES(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start_i(s1), .val_i(v1), .dat_i(d1), .lst_i(l1),
`ifdef CRC32_PARTIAL_EN
        .nbyte_i(nb1),
`endif
        .busy_o(b1), .val_o(vo1), .done_o(dn1), .dat_o(o1)
    );

    int n_vec = 0;
    int n_err = 0;
    int vcnt4 = 0;
    int vcnt1 = 0;
    int snap;
    logic [31:0] exp4_q[$];
    logic [31:0] exp1_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference, LSB-first, reflected polynomial.
    function automatic logic [31:0] crc_model(input string s);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] pack4(input string s, input int off);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            if (off + i < s.len()) r[8*i +: 8] = s[off + i];
        return r;
    endfunction

    // Completion monitor: every val_o must match the next queued expectation.
    always @(negedge clk) begin
        if (rstn && vo4) begin
            vcnt4++;
            if (exp4_q.size() == 0) check("dut4 unexpected val_o", 32'd1, 32'd0);
            else                    check("dut4 crc", o4, exp4_q.pop_front());
        end
        if (rstn && vo1) begin
            vcnt1++;
            if (exp1_q.size() == 0) check("dut1 unexpected val_o", 32'd1, 32'd0);
            else                    check("dut1 crc", o1, exp1_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        s4 = 1'b0; v4 = 1'b0; l4 = 1'b0; d4 = 32'h0; nb4 = 2'd0;
        s1 = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = 8'h0; nb1 = 1'b0;
    endtask

    task automatic drive4(input logic s, input logic v, input logic l,
                          input logic [31:0] d, input logic [1:0] nb);
        s4 = s; v4 = v; l4 = l; d4 = d; nb4 = nb;
        tick();
    endtask

    task automatic drive1(input logic s, input logic v, input logic l, input logic [7:0] d);
        s1 = s; v1 = v; l1 = l; d1 = d;
        tick();
    endtask

    // Beats of a byte string on dut1; start either on its own cycle or with byte 0.
    task automatic send1(input string s, input bit start_with_first);
        if (!start_with_first) drive1(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < s.len(); i++)
            drive1(start_with_first && i == 0, 1'b1, i == s.len() - 1, s[i]);
    endtask

    // Full beats of a string (length a multiple of 4) on dut4.
    task automatic send4(input string s, input bit start_with_first);
        int nb;
        nb = s.len() / 4;
        if (!start_with_first) drive4(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        for (int i = 0; i < nb; i++)
            drive4(start_with_first && i == 0, 1'b1, i == nb - 1, pack4(s, 4 * i), 2'd0);
    endtask

    initial begin
        s4 = 1'b0; v4 = 1'b0; l4 = 1'b0; d4 = 32'h0; nb4 = 2'd0;
        s1 = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = 8'h0; nb1 = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dat4", o4, 32'h0);
        check("reset val4", {31'h0, vo4}, 32'h0);
        check("reset done4", {31'h0, dn4}, 32'h0);
        check("reset busy4", {31'h0, b4}, 32'h0);
        check("reset dat1", o1, 32'h0);
        rstn = 1'b1;
        tick();

        // IDLE ignores beats.
        drive4(1'b0, 1'b1, 1'b1, pack4("IEND", 0), 2'd0);
        tick();
        check("idle beat val4 count", 32'(vcnt4), 32'd0);
        check("idle beat busy4", {31'h0, b4}, 32'h0);

        // "123456789" byte-wide: check value, latency, levels.
        exp1_q.push_back(32'hCBF43926);
        drive1(1'b1, 1'b0, 1'b0, 8'h00);
        check("busy1 after start", {31'h0, b1}, 32'h1);
        for (int i = 0; i < 8; i++) drive1(1'b0, 1'b1, 1'b0, 8'h31 + 8'(i));
        check("no val1 before last", {31'h0, vo1}, 32'h0);
        drive1(1'b0, 1'b1, 1'b1, 8'h39);
        check("val1 pulse", {31'h0, vo1}, 32'h1);
        check("check value 123456789", o1, 32'hCBF43926);
        check("done1 set", {31'h0, dn1}, 32'h1);
        check("busy1 cleared", {31'h0, b1}, 32'h0);
        tick();
        check("val1 one cycle", {31'h0, vo1}, 32'h0);
        check("done1 holds", {31'h0, dn1}, 32'h1);
        check("dat1 holds", o1, 32'hCBF43926);

        // "IEND" as a single start+val+lst beat.
        exp4_q.push_back(32'hAE426082);
        drive4(1'b1, 1'b1, 1'b1, pack4("IEND", 0), 2'd0);
        check("iend single beat", o4, 32'hAE426082);
        check("iend val4", {31'h0, vo4}, 32'h1);
        check("iend done4", {31'h0, dn4}, 32'h1);
        check("iend busy4", {31'h0, b4}, 32'h0);
        tick();

        // Abort: garbage beats then restart.
        snap = vcnt4;
        exp4_q.push_back(32'hAE426082);
        drive4(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        check("abort done4 cleared", {31'h0, dn4}, 32'h0);
        drive4(1'b0, 1'b1, 1'b0, $urandom, 2'd0);
        drive4(1'b0, 1'b1, 1'b0, $urandom, 2'd0);
        drive4(1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
        check("abort no val4", {31'h0, vo4}, 32'h0);
        check("abort busy4", {31'h0, b4}, 32'h1);
        drive4(1'b0, 1'b1, 1'b1, pack4("IEND", 0), 2'd0);
        check("abort result", o4, 32'hAE426082);
        tick();
        check("abort one val4", 32'(vcnt4 - snap), 32'd1);

        // Multi-beat, start with the first beat over a stale register.
        exp4_q.push_back(crc_model("The quick brown fox jumps over the lazy dog."));
        send4("The quick brown fox jumps over the lazy dog.", 1'b1);
        tick();

        // Back-to-back on dut1: second start in the val_o cycle.
        snap = vcnt1;
        exp1_q.push_back(32'hAE426082);
        exp1_q.push_back(32'hCBF43926);
        send1("IEND", 1'b0);
        check("b2b first val1", {31'h0, vo1}, 32'h1);
        check("b2b first crc", o1, 32'hAE426082);
        drive1(1'b1, 1'b0, 1'b0, 8'h00);
        check("b2b done1 dropped", {31'h0, dn1}, 32'h0);
        check("b2b busy1", {31'h0, b1}, 32'h1);
        for (int i = 0; i < 9; i++) drive1(1'b0, 1'b1, i == 8, 8'h31 + 8'(i));
        check("b2b second crc", o1, 32'hCBF43926);
        tick();
        check("b2b two val1", 32'(vcnt1 - snap), 32'd2);

        exp1_q.push_back(32'h414FA339);
        send1("The quick brown fox jumps over the lazy dog", 1'b1);
        tick();

`ifdef CRC32_PARTIAL_EN
        exp4_q.push_back(32'hCBF43926);
        drive4(1'b1, 1'b1, 1'b0, pack4("1234", 0), 2'd1);
        drive4(1'b0, 1'b1, 1'b0, pack4("5678", 0), 2'd1);
        drive4(1'b0, 1'b1, 1'b1, {24'h787878, 8'h39}, 2'd1);
        check("partial 123456789", o4, 32'hCBF43926);
        tick();
        exp4_q.push_back(32'hE8B7BE43);
        drive4(1'b1, 1'b1, 1'b1, {24'hA5A5A5, 8'h61}, 2'd1);
        check("partial a", o4, 32'hE8B7BE43);
        tick();
        exp4_q.push_back(crc_model("IHD"));
        drive4(1'b1, 1'b1, 1'b1, {8'hFF, 24'h444849}, 2'd3);
        check("partial three", o4, crc_model("IHD"));
        tick();
`endif

        // Reset mid-chunk: outputs drop immediately, no val_o afterwards.
        snap = vcnt4;
        drive4(1'b1, 1'b1, 1'b0, pack4("IEND", 0), 2'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("midreset dat4", o4, 32'h0);
        check("midreset busy4", {31'h0, b4}, 32'h0);
        check("midreset done4", {31'h0, dn4}, 32'h0);
        check("midreset dat1", o1, 32'h0);
        check("midreset done1", {31'h0, dn1}, 32'h0);
        #3;
        rstn = 1'b1;
        tick();
        drive4(1'b0, 1'b1, 1'b0, $urandom, 2'd0);
        drive4(1'b0, 1'b1, 1'b1, $urandom, 2'd0);
        tick();
        check("post reset no val4", 32'(vcnt4 - snap), 32'd0);
        check("post reset idle busy4", {31'h0, b4}, 32'h0);
        check("post reset idle dat4", o4, 32'h0);
        exp4_q.push_back(32'hAE426082);
        send4("IEND", 1'b0);
        check("post reset iend", o4, 32'hAE426082);
        tick();

        check("dut4 pending expectations", 32'(exp4_q.size()), 32'd0);
        check("dut1 pending expectations", 32'(exp1_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
